// File: rtl/branch_resolver.sv
// Branch resolver: accepts a conditional branch, drives the ALU to SUB, samples its flags
// after ALU_LAT wait cycles and returns taken / next-PC. Optional counters under BRANCH_STATS_EN.
module branch_resolver #(
    parameter int DATA_W  = 64,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [DATA_W-1:0] req_pc,
    input  logic [DATA_W-1:0] req_imm,
    output logic [2:0]        alu_funct,
    input  logic              alu_equal,
    input  logic              alu_less,
    input  logic              alu_overflow,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_taken,
    output logic [DATA_W-1:0] resp_next_pc,
    output logic              resp_illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       stat_taken,
    output logic [31:0]       stat_not_taken,
    output logic [31:0]       stat_ovf
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, EVAL, RESP} state_t;

    localparam logic [2:0] FUNCT_SUM = 3'd0;
    localparam logic [2:0] FUNCT_SUB = 3'd2;
    localparam logic [2:0] KIND_BEQ  = 3'b000;
    localparam logic [2:0] KIND_BNE  = 3'b001;
    localparam logic [2:0] KIND_BLT  = 3'b100;
    localparam logic [2:0] KIND_BGE  = 3'b101;
    localparam logic [2:0] CNT_LAST  = 3'(ALU_LAT - 1);
    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        kind_q, kind_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] next_pc_q, next_pc_d;
    logic              resp_valid_q, resp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic [2:0]        alu_funct_q, alu_funct_d;
    logic              eval_taken;
    logic              eval_legal;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken_q, stat_taken_d;
    logic [31:0] stat_not_taken_q, stat_not_taken_d;
    logic [31:0] stat_ovf_q, stat_ovf_d;
`else
    logic unused_overflow;
    assign unused_overflow = alu_overflow;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        kind_d       = kind_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        taken_d      = taken_q;
        illegal_d    = illegal_q;
        next_pc_d    = next_pc_q;
        eval_taken   = 1'b0;
        eval_legal   = 1'b1;
`ifdef BRANCH_STATS_EN
        stat_taken_d     = stat_taken_q;
        stat_not_taken_d = stat_not_taken_q;
        stat_ovf_d       = stat_ovf_q;
`endif

        case (kind_q)
            KIND_BEQ: eval_taken = alu_equal;
            KIND_BNE: eval_taken = !alu_equal;
            KIND_BLT: eval_taken = alu_less;
            KIND_BGE: eval_taken = !alu_less;
            default:  eval_legal = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    kind_d  = req_kind;
                    pc_d    = req_pc;
                    imm_d   = req_imm;
                    cnt_d   = '0;
                    state_d = (ALU_LAT > 0) ? WAIT : EVAL;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = EVAL;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            EVAL: begin
                taken_d   = eval_taken;
                illegal_d = !eval_legal;
                next_pc_d = eval_taken ? (pc_q + imm_q) : (pc_q + PC_STEP);
                state_d   = RESP;
`ifdef BRANCH_STATS_EN
                if (eval_legal && eval_taken && stat_taken_q != '1)
                    stat_taken_d = stat_taken_q + 32'd1;
                if (eval_legal && !eval_taken && stat_not_taken_q != '1)
                    stat_not_taken_d = stat_not_taken_q + 32'd1;
                if (alu_overflow && stat_ovf_q != '1)
                    stat_ovf_d = stat_ovf_q + 32'd1;
`endif
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake and ALU select are registered from the next state so they change on edges only.
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        alu_funct_d  = (state_d == WAIT || state_d == EVAL) ? FUNCT_SUB : FUNCT_SUM;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            kind_q       <= '0;
            pc_q         <= '0;
            imm_q        <= '0;
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
            next_pc_q    <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            alu_funct_q  <= FUNCT_SUM;
`ifdef BRANCH_STATS_EN
            stat_taken_q     <= '0;
            stat_not_taken_q <= '0;
            stat_ovf_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its inputs.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            kind_q       <= kind_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            taken_q      <= taken_d;
            illegal_q    <= illegal_d;
            next_pc_q    <= next_pc_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            alu_funct_q  <= alu_funct_d;
`ifdef BRANCH_STATS_EN
            stat_taken_q     <= stat_taken_d;
            stat_not_taken_q <= stat_not_taken_d;
            stat_ovf_q       <= stat_ovf_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign alu_funct    = alu_funct_q;
    assign resp_valid   = resp_valid_q;
    assign resp_taken   = taken_q;
    assign resp_next_pc = next_pc_q;
    assign resp_illegal = illegal_q;
`ifdef BRANCH_STATS_EN
    assign stat_taken     = stat_taken_q;
    assign stat_not_taken = stat_not_taken_q;
    assign stat_ovf       = stat_ovf_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed plan cases, back-pressure, random traffic
// against a rule-level reference model, asynchronous reset mid-flight, optional BRANCH_STATS_EN.
module tb_branch_resolver;

    localparam int DW  = 64;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          reset, reset7;
    logic          req_valid, resp_ready;
    logic [2:0]    req_kind;
    logic [DW-1:0] req_pc, req_imm;
    logic          alu_equal, alu_less, alu_overflow;

    logic          req_ready, resp_valid, resp_taken, resp_illegal;
    logic [2:0]    alu_funct;
    logic [DW-1:0] resp_next_pc;
    logic          req_ready7, resp_valid7, resp_taken7, resp_illegal7;
    logic [2:0]    alu_funct7;
    logic [DW-1:0] resp_next_pc7;

    int n_checks = 0;
    int n_errors = 0;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken, stat_not_taken, stat_ovf;
    logic [31:0] stat_taken7, stat_not_taken7, stat_ovf7;
    logic [31:0] exp_taken = 0, exp_not_taken = 0, exp_ovf = 0;
`endif

    always #5 clk = ~clk;

    branch_resolver #(.DATA_W(DW), .ALU_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_pc(req_pc), .req_imm(req_imm), .alu_funct(alu_funct),
        .alu_equal(alu_equal), .alu_less(alu_less), .alu_overflow(alu_overflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_taken(resp_taken),
        .resp_next_pc(resp_next_pc), .resp_illegal(resp_illegal)
`ifdef BRANCH_STATS_EN
        , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken), .stat_ovf(stat_ovf)
`endif
    );

    branch_resolver #(.DATA_W(DW), .ALU_LAT(7)) dut7 (
        .clk(clk), .reset(reset7),
        .req_valid(req_valid), .req_ready(req_ready7), .req_kind(req_kind),
        .req_pc(req_pc), .req_imm(req_imm), .alu_funct(alu_funct7),
        .alu_equal(alu_equal), .alu_less(alu_less), .alu_overflow(alu_overflow),
        .resp_valid(resp_valid7), .resp_ready(resp_ready), .resp_taken(resp_taken7),
        .resp_next_pc(resp_next_pc7), .resp_illegal(resp_illegal7)
`ifdef BRANCH_STATS_EN
        , .stat_taken(stat_taken7), .stat_not_taken(stat_not_taken7), .stat_ovf(stat_ovf7)
`endif
    );

    // Reference decision straight from the branch rules.
    function automatic void ref_branch(input logic [2:0] kind, input logic [DW-1:0] pc,
                                       input logic [DW-1:0] imm, input logic eq, input logic less,
                                       output logic taken, output logic illegal,
                                       output logic [DW-1:0] npc);
        illegal = 1'b0;
        taken   = 1'b0;
        case (kind)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = less;
            3'b101:  taken = !less;
            default: illegal = 1'b1;
        endcase
        npc = taken ? pc + imm : pc + 64'd4;
    endfunction

    // One full transaction on dut, starting and ending on a negedge with dut in IDLE.
    task automatic run_branch(input string name, input logic [2:0] kind, input logic [DW-1:0] pc,
                              input logic [DW-1:0] imm, input logic eq, input logic less,
                              input logic ovf, input int hold);
        logic          t, il;
        logic [DW-1:0] npc;
        logic [DW+2:0] resp_snap;
        ref_branch(kind, pc, imm, eq, less, t, il, npc);

        n_checks++;
        if ({req_ready, alu_funct, resp_valid} !== {1'b1, 3'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL %s idle: ready/funct/valid=%b/%0d/%b want 1/0/0", name, req_ready, alu_funct, resp_valid);
        end
        req_valid = 1'b1; req_kind = kind; req_pc = pc; req_imm = imm; resp_ready = 1'b0;
        alu_equal = !eq; alu_less = !less; alu_overflow = !ovf;
        @(posedge clk); @(negedge clk);
        // Junk request held on the bus while busy must be ignored.
        req_kind = 3'($urandom); req_pc = {$urandom, $urandom}; req_imm = {$urandom, $urandom};

        for (int i = 0; i <= LAT; i++) begin
            if (i == LAT) begin
                alu_equal = eq; alu_less = less; alu_overflow = ovf;
            end
            n_checks++;
            if ({alu_funct, req_ready, resp_valid} !== {3'd2, 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL %s busy%0d: funct/ready/valid=%0d/%b/%b want 2/0/0", name, i, alu_funct, req_ready, resp_valid);
            end
            @(posedge clk); @(negedge clk);
        end

        alu_equal = !eq; alu_less = !less; alu_overflow = !ovf;
        resp_snap = {resp_valid, resp_taken, resp_illegal, resp_next_pc};
        for (int i = 0; i <= hold; i++) begin
            n_checks++;
            if ({resp_valid, resp_taken, resp_illegal, resp_next_pc, alu_funct, req_ready} !==
                {1'b1, t, il, npc, 3'd0, 1'b0} ||
                {resp_valid, resp_taken, resp_illegal, resp_next_pc} !== resp_snap) begin
                n_errors++;
                $display("FAIL %s resp%0d: v/t/il/pc=%b/%b/%b/%h funct=%0d rdy=%b want 1/%b/%b/%h funct=0 rdy=0",
                         name, i, resp_valid, resp_taken, resp_illegal, resp_next_pc, alu_funct, req_ready, t, il, npc);
            end
            if (i < hold) begin
                alu_equal = 1'($urandom); alu_less = 1'($urandom);
                @(posedge clk); @(negedge clk);
            end
        end

        resp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
        n_checks++;
        if ({resp_valid, req_ready, alu_funct} !== {1'b0, 1'b1, 3'd0}) begin
            n_errors++;
            $display("FAIL %s release: valid/ready/funct=%b/%b/%0d want 0/1/0", name, resp_valid, req_ready, alu_funct);
        end
`ifdef BRANCH_STATS_EN
        if (!il && t && exp_taken != 32'hFFFF_FFFF) exp_taken++;
        if (!il && !t && exp_not_taken != 32'hFFFF_FFFF) exp_not_taken++;
        if (ovf && exp_ovf != 32'hFFFF_FFFF) exp_ovf++;
`endif
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`ifdef BRANCH_STATS_EN
        exp_taken = 0; exp_not_taken = 0; exp_ovf = 0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; reset7 = 1'b1;
        req_valid = 1'b0; resp_ready = 1'b0; req_kind = '0; req_pc = '0; req_imm = '0;
        alu_equal = 1'b0; alu_less = 1'b0; alu_overflow = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, resp_taken, resp_illegal, resp_next_pc, alu_funct} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 3'd0}) begin
            n_errors++;
            $display("FAIL reset_state: rdy/v/t/il/pc/funct=%b/%b/%b/%b/%h/%0d want 1/0/0/0/0/0",
                     req_ready, resp_valid, resp_taken, resp_illegal, resp_next_pc, alu_funct);
        end
    endtask

    task automatic test_directed();
        run_branch("beq_taken",  3'b000, 64'h1000, 64'h40, 1'b1, 1'b0, 1'b0, 0);
        run_branch("blt_not",    3'b100, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b0, 0);
        run_branch("blt_taken",  3'b100, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b1, 1'b0, 0);
        run_branch("bne_wrap",   3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b0, 1'b0, 1'b0, 0);
        run_branch("illegal010", 3'b010, 64'h3000, 64'h100, 1'b1, 1'b1, 1'b0, 0);
        run_branch("bge_taken",  3'b101, 64'h4000, 64'h20, 1'b0, 1'b0, 1'b1, 0);
        run_branch("beq_not",    3'b000, 64'h5000, 64'h20, 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_branch("hold5",      3'b101, 64'h6000, 64'h80, 1'b1, 1'b1, 1'b0, 5);
        run_branch("after_hold", 3'b000, 64'h7000, 64'h10, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [2:0] kinds [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b011, 3'b111};
        for (int n = 0; n < 40; n++) begin
            run_branch("random", kinds[$urandom_range(0, 5)], {$urandom, $urandom}, {$urandom, $urandom},
                       1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
`ifdef BRANCH_STATS_EN
        n_checks++;
        if ({stat_taken, stat_not_taken, stat_ovf} !== {exp_taken, exp_not_taken, exp_ovf}) begin
            n_errors++;
            $display("FAIL random_stats: %0d/%0d/%0d want %0d/%0d/%0d",
                     stat_taken, stat_not_taken, stat_ovf, exp_taken, exp_not_taken, exp_ovf);
        end
`endif
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        reset = 1'b1; reset7 = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_kind = 3'b000; req_pc = 64'h8000; req_imm = 64'h40; alu_equal = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({alu_funct7, req_ready7, resp_valid7} !== {3'd2, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL lat7_busy: funct/ready/valid=%0d/%b/%b want 2/0/0", alu_funct7, req_ready7, resp_valid7);
        end
        @(posedge clk); @(posedge clk); @(negedge clk);
        #2 reset7 = 1'b1;
        #1;
        n_checks++;
        if ({req_ready7, resp_valid7, alu_funct7} !== {1'b1, 1'b0, 3'd0}) begin
            n_errors++;
            $display("FAIL async_reset: ready/valid/funct=%b/%b/%0d want 1/0/0", req_ready7, resp_valid7, alu_funct7);
        end
        @(negedge clk);
        reset7 = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if ({resp_valid7, req_ready7} !== {1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL dropped_req cycle %0d: valid/ready=%b/%b want 0/1", i, resp_valid7, req_ready7);
            end
        end
        resp_ready = 1'b0; reset7 = 1'b1;
        reset = 1'b0;
`ifdef BRANCH_STATS_EN
        exp_taken = 0; exp_not_taken = 0; exp_ovf = 0;
`endif
        @(negedge clk);
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        pulse_reset();
        run_branch("st_t1",  3'b000, 64'h100, 64'h10, 1'b1, 1'b0, 1'b0, 0);
        run_branch("st_t2",  3'b001, 64'h200, 64'h10, 1'b0, 1'b0, 1'b0, 0);
        run_branch("st_t3",  3'b100, 64'h300, 64'h10, 1'b0, 1'b1, 1'b0, 0);
        run_branch("st_n1",  3'b101, 64'h400, 64'h10, 1'b0, 1'b1, 1'b1, 0);
        run_branch("st_n2",  3'b000, 64'h500, 64'h10, 1'b0, 1'b0, 1'b0, 0);
        n_checks++;
        if ({stat_taken, stat_not_taken, stat_ovf} !== {32'd3, 32'd2, 32'd1}) begin
            n_errors++;
            $display("FAIL stats_321: %0d/%0d/%0d want 3/2/1", stat_taken, stat_not_taken, stat_ovf);
        end
        dut.stat_taken_q = 32'hFFFF_FFFF;
        exp_taken = 32'hFFFF_FFFF;
        run_branch("st_sat", 3'b000, 64'h600, 64'h10, 1'b1, 1'b0, 1'b0, 0);
        n_checks++;
        if (stat_taken !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL stats_saturate: %h want ffffffff", stat_taken);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midflight();
        run_branch("post_reset", 3'b001, 64'h9000, 64'h30, 1'b1, 1'b0, 1'b0, 0);
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
